// File: rtl/apb_req_arbiter.sv
// Round-robin front end that shares one four-slave APB bus between NUM_REQ requesters,
// with address decode, pready-stall timeout and decode-error completion.
module apb_req_arbiter #(
    parameter int         NUM_REQ   = 4,
    parameter int         TIMEOUT   = 16,
    parameter logic [2:0] PPROT_DEF = 3'b000
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    input  logic [4*NUM_REQ-1:0]  req_strb,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [31:0]           req_rdata,
    output logic                  req_err,
    output logic [3:0]            psel,
    output logic                  penable,
    output logic [31:0]           paddr,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    output logic [2:0]            pprot,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DECERR = 2'd3;

    localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

    logic [31:0] w_addr  [NUM_REQ];
    logic [31:0] w_wdata [NUM_REQ];
    logic [3:0]  w_strb  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = req_addr[32*gi +: 32];
            assign w_wdata[gi] = req_wdata[32*gi +: 32];
            assign w_strb[gi]  = req_strb[4*gi +: 4];
        end
    endgenerate

    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_owner;
    logic [TW-1:0]      r_tcnt;
    logic [3:0]         r_sel;
    logic [31:0]        r_addr;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;
    logic [NUM_REQ-1:0] r_done;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic [NUM_REQ-1:0] w_owner_oh;
    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_cand;
    logic [PW-1:0]      w_scan_idx;
    logic [PW-1:0]      w_win;
    logic               w_found;
    logic [PW-1:0]      w_ptr_next;
    logic [31:0]        w_win_addr;
    logic               w_dec_err;
    logic               w_tmo;
    logic               w_complete;
    logic               w_arb;

    // The requester being completed (or whose done pulse is showing) still has
    // req_valid high, so it is excluded to avoid granting the same request twice.
    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    assign w_mask     = (r_state == S_ACCESS) ? w_owner_oh : r_done;
    assign w_cand     = req_valid & ~w_mask;

    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
            if (w_cand[w_scan_idx]) begin
                w_found = 1'b1;
                w_win   = w_scan_idx;
            end
        end
    end

    assign w_ptr_next = (w_win == LAST_REQ) ? '0 : w_win + 1'b1;
    assign w_win_addr = w_addr[w_win];
    assign w_dec_err  = |w_win_addr[31:14];

    generate
        if (TIMEOUT > 0) begin : g_tmo
            assign w_tmo = !pready && (r_tcnt == TW'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign w_tmo = 1'b0;
        end
    endgenerate

    assign w_complete = (r_state == S_ACCESS) && (pready || w_tmo);
    assign w_arb      = (r_state == S_IDLE) || w_complete;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_tcnt  <= '0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            case (r_state)
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    r_tcnt  <= '0;
                end
                S_ACCESS: begin
                    if (w_complete) begin
                        r_done  <= w_owner_oh;
                        r_state <= S_IDLE;
                        if (pready) begin
                            r_err   <= pslverr;
                            r_rdata <= r_write ? 32'd0 : prdata;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DECERR: begin
                    r_done  <= w_owner_oh;
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                end
            endcase
            // A grant overrides the IDLE fall-back, giving back-to-back SETUP.
            if (w_arb && w_found) begin
                r_owner <= w_win;
                r_ptr   <= w_ptr_next;
                r_addr  <= w_win_addr;
                r_write <= req_write[w_win];
                r_wdata <= w_wdata[w_win];
                r_strb  <= req_write[w_win] ? w_strb[w_win] : 4'd0;
                r_sel   <= 4'b0001 << w_win_addr[13:12];
                r_state <= w_dec_err ? S_DECERR : S_SETUP;
            end
        end
    end

    assign psel      = ((r_state == S_SETUP) || (r_state == S_ACCESS)) ? r_sel : 4'd0;
    assign penable   = (r_state == S_ACCESS);
    assign paddr     = r_addr;
    assign pwrite    = r_write;
    assign pwdata    = r_wdata;
    assign pstrb     = r_strb;
    assign pprot     = PPROT_DEF;
    assign req_done  = r_done;
    assign req_rdata = r_rdata;
    assign req_err   = r_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed protocol checks followed by random contention
// rounds predicted by a round-robin order model and a simple address-driven slave.
module tb_apb_req_arbiter;
    localparam int N = 4;

    logic            pclk = 1'b0;
    logic            preset;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [32*N-1:0] req_wdata;
    logic [4*N-1:0]  req_strb;
    logic [N-1:0]    req_done;
    logic [31:0]     req_rdata;
    logic            req_err;
    logic [3:0]      psel;
    logic            penable;
    logic [31:0]     paddr;
    logic            pwrite;
    logic [31:0]     pwdata;
    logic [3:0]      pstrb;
    logic [2:0]      pprot;
    logic [31:0]     prdata;
    logic            pready;
    logic            pslverr;

    logic            auto_mode;
    logic            man_pready;
    logic            man_pslverr;
    logic [31:0]     man_prdata;
    logic [1:0]      wcnt = 2'd0;
    logic            a_pready;

    int n_tests = 0;
    int n_fail  = 0;
    int ord[5]  = '{0, 1, 2, 3, 0};

    apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT(16), .PPROT_DEF(3'b000)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Auto slave: waits paddr[5:4] ACCESS cycles, errors when paddr[7:6]==3,
    // and returns read data derived from the address.
    always @(posedge pclk) begin
        if (psel == 4'd0 || !penable || pready) wcnt <= 2'd0;
        else                                    wcnt <= wcnt + 2'd1;
    end
    assign a_pready = (psel != 4'd0) && penable && (wcnt == paddr[5:4]);
    assign pready   = auto_mode ? a_pready : man_pready;
    assign prdata   = auto_mode ? {paddr[15:0], ~paddr[15:0]} : man_prdata;
    assign pslverr  = auto_mode ? (a_pready && paddr[7:6] == 2'b11) : man_pslverr;

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] oh(input int i);
        return 32'd1 << i;
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
        req_addr[32*i +: 32]  = a;
        req_write[i]          = w;
        req_wdata[32*i +: 32] = d;
        req_strb[4*i +: 4]    = s;
        req_valid[i]          = 1'b1;
    endtask

    task automatic apply_reset();
        preset    = 1'b1;
        req_valid = '0;
        step();
        step();
        preset = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output logic [N-1:0] dv);
        bit got;
        got = 1'b0;
        dv  = '0;
        for (int n = 0; n < bound && !got; n++) begin
            step();
            if (req_done != '0) begin
                got = 1'b1;
                dv  = req_done;
            end
        end
        n_tests++;
        assert (got) else begin
            n_fail++;
            $error("FAIL %s: observed no req_done in %0d cycles, expected a completion", tag, bound);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected the run to end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] dv;
        logic [N-1:0] sub;
        int           acc;
        bit           got;
        int           q[$];
        int           e;
        int           mptr;
        logic         m_bad[N];
        logic [31:0]  m_addr[N];
        logic         m_wr[N];
        logic         exp_err;
        logic [31:0]  exp_rd;
        logic [31:0]  exp_rr[5];

        preset = 1'b1; req_valid = '0; req_addr = '0; req_write = '0;
        req_wdata = '0; req_strb = '0;
        auto_mode = 1'b1; man_pready = 1'b0; man_pslverr = 1'b0; man_prdata = '0;

        // Reset state
        step(); step();
        check("rst_psel", psel, 0);       check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);     check("rst_pwrite", pwrite, 0);
        check("rst_pwdata", pwdata, 0);   check("rst_pstrb", pstrb, 0);
        check("rst_done", req_done, 0);   check("rst_rdata", req_rdata, 0);
        check("rst_err", req_err, 0);     check("rst_pprot", pprot, 0);
        preset = 1'b0;
        step();

        // Single zero-wait write from requester 0
        set_req(0, 32'h0000_1004, 1'b1, 32'hA5A5_5A5A, 4'hF);
        step();
        check("wr_c1_psel", psel, 4'b0010);   check("wr_c1_penable", penable, 0);
        check("wr_c1_paddr", paddr, 32'h0000_1004);
        check("wr_c1_pwrite", pwrite, 1);     check("wr_c1_pwdata", pwdata, 32'hA5A5_5A5A);
        check("wr_c1_pstrb", pstrb, 4'hF);    check("wr_c1_done", req_done, 0);
        step();
        check("wr_c2_psel", psel, 4'b0010);   check("wr_c2_penable", penable, 1);
        check("wr_c2_done", req_done, 0);
        step();
        check("wr_c3_done", req_done, oh(0)); check("wr_c3_err", req_err, 0);
        check("wr_c3_rdata", req_rdata, 0);   check("wr_c3_psel", psel, 0);
        req_valid[0] = 1'b0;
        step();
        check("wr_c4_done", req_done, 0);

        // Read with three wait states from requester 2
        auto_mode = 1'b0; man_pready = 1'b0; man_prdata = 32'hDEAD_BEEF;
        set_req(2, 32'h0000_3000, 1'b0, 32'h1111_2222, 4'hF);
        step();
        check("rd_setup_psel", psel, 4'b1000); check("rd_setup_penable", penable, 0);
        check("rd_setup_pstrb", pstrb, 0);     check("rd_setup_pwrite", pwrite, 0);
        for (int n = 1; n <= 4; n++) begin
            step();
            check("rd_access_penable", penable, 1);
            check("rd_access_psel", psel, 4'b1000);
            if (n == 4) man_pready = 1'b1;
        end
        step();
        check("rd_done", req_done, oh(2));      check("rd_rdata", req_rdata, 32'hDEAD_BEEF);
        check("rd_err", req_err, 0);            check("rd_done_penable", penable, 0);
        req_valid[2] = 1'b0; man_pready = 1'b0;
        step();

        // Decode error from requester 1
        auto_mode = 1'b1;
        set_req(1, 32'h0001_0000, 1'b0, 32'd0, 4'hF);
        step();
        check("dec_c1_psel", psel, 0);          check("dec_c1_done", req_done, 0);
        step();
        check("dec_done", req_done, oh(1));     check("dec_err", req_err, 1);
        check("dec_rdata", req_rdata, 0);       check("dec_psel", psel, 0);
        req_valid[1] = 1'b0;
        step();

        // pready stuck low: timeout after 16 ACCESS cycles
        auto_mode = 1'b0; man_pready = 1'b0;
        set_req(3, 32'h0000_2000, 1'b1, 32'h0BAD_F00D, 4'h3);
        step();
        check("to_setup_psel", psel, 4'b0100);
        acc = 0; got = 1'b0; dv = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            step();
            if (penable) acc++;
            if (req_done != '0) begin got = 1'b1; dv = req_done; end
        end
        check("to_done", dv, oh(3));            check("to_access_cycles", acc, 16);
        check("to_err", req_err, 1);            check("to_rdata", req_rdata, 0);
        req_valid[3] = 1'b0;
        step();

        // pready arriving in the 16th ACCESS cycle beats the timeout
        man_prdata = 32'h1357_9BDF;
        set_req(0, 32'h0000_0008, 1'b0, 32'd0, 4'hF);
        step();
        for (int n = 1; n <= 16; n++) begin
            step();
            if (n == 16) man_pready = 1'b1;
        end
        step();
        check("edge_done", req_done, oh(0));    check("edge_err", req_err, 0);
        check("edge_rdata", req_rdata, 32'h1357_9BDF);
        req_valid[0] = 1'b0; man_pready = 1'b0;
        step();

        // Slave error on a normal read
        man_pready = 1'b1; man_pslverr = 1'b1; man_prdata = 32'h1234_5678;
        set_req(1, 32'h0000_0FF0, 1'b0, 32'd0, 4'hF);
        wait_done("slverr_wait", 10, dv);
        check("slverr_done", dv, oh(1));        check("slverr_err", req_err, 1);
        check("slverr_rdata", req_rdata, 32'h1234_5678);
        req_valid[1] = 1'b0; man_pslverr = 1'b0; man_pready = 1'b0;
        step();

        // Reset during ACCESS aborts without req_done; re-issued request completes
        set_req(2, 32'h0000_3010, 1'b1, 32'hCAFE_0001, 4'hC);
        step(); step();
        check("rst_mid_penable", penable, 1);
        preset = 1'b1;
        step();
        check("rst_mid_psel", psel, 0);         check("rst_mid_penable_after", penable, 0);
        check("rst_mid_done", req_done, 0);
        preset = 1'b0; man_pready = 1'b1;
        wait_done("rst_reissue_wait", 10, dv);
        check("rst_reissue_done", dv, oh(2));   check("rst_reissue_err", req_err, 0);
        req_valid[2] = 1'b0; man_pready = 1'b0;
        step();

        // All four contend; requester 0 re-requests once -> order 0,1,2,3,0 back-to-back
        auto_mode = 1'b1;
        apply_reset();
        for (int i = 0; i < N; i++)
            set_req(i, (32'(i) << 12) | (32'(i) << 8), (i % 2) == 0, 32'h1000_0000 * i, 4'hF);
        exp_rr[0] = 32'd0;
        exp_rr[1] = slave_rd(32'h0000_1100);
        exp_rr[2] = 32'd0;
        exp_rr[3] = slave_rd(32'h0000_3300);
        exp_rr[4] = slave_rd(32'h0000_0040);
        for (int k = 0; k < 5; k++) begin
            wait_done("rr_wait", 20, dv);
            check("rr_grant", dv, oh(ord[k]));
            check("rr_rdata", req_rdata, exp_rr[k]);
            check("rr_err", req_err, 0);
            if (k < 4) begin
                check("rr_b2b_psel", psel, 32'd1 << ord[k+1]);
                check("rr_b2b_penable", penable, 0);
            end
            if (k == 0) set_req(0, 32'h0000_0040, 1'b0, 32'd0, 4'hF);
            else        req_valid = req_valid & ~dv;
        end
        step();

        // Random contention rounds against a round-robin order model
        apply_reset();
        mptr = 0;
        for (int rnd = 0; rnd < 40; rnd++) begin
            sub = N'($urandom_range(1, (1 << N) - 1));
            q.delete();
            for (int k = 0; k < N; k++)
                if (sub[(mptr + k) % N]) q.push_back((mptr + k) % N);
            for (int i = 0; i < N; i++) begin
                if (sub[i]) begin
                    m_bad[i]  = ($urandom_range(0, 5) == 0);
                    m_addr[i] = m_bad[i] ? ($urandom | 32'h0000_4000) : ($urandom & 32'h0000_3FFF);
                    m_wr[i]   = 1'($urandom_range(0, 1));
                    set_req(i, m_addr[i], m_wr[i], $urandom, 4'($urandom));
                end
            end
            while (q.size() > 0) begin
                e = q.pop_front();
                wait_done("rnd_wait", 40, dv);
                check("rnd_grant", dv, oh(e));
                if (m_bad[e]) begin
                    exp_err = 1'b1;
                    exp_rd  = 32'd0;
                end else begin
                    exp_err = (m_addr[e][7:6] == 2'b11);
                    exp_rd  = m_wr[e] ? 32'd0 : slave_rd(m_addr[e]);
                end
                check("rnd_err", req_err, exp_err);
                check("rnd_rdata", req_rdata, exp_rd);
                mptr = (e + 1) % N;
                req_valid = req_valid & ~dv;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
